// File: rtl/uart_tx.sv
// UART transmitter with a one-byte holding register, optional parity and
// programmable oversampling for data and stop periods.
// Latency: an accepted byte leaves IDLE one clk after acceptance; frames
//   run back to back with no idle ticks between them.
// Backpressure: tx_ready drops while the holding register is full; tx_start
//   is ignored until the register empties (when its byte enters START).
//
// Ports:
//   clk          system clock, all state changes on its rising edge
//   rst_n        asynchronous active-low reset
//   tick         one-clk oversampling strobe from the baud generator
//   tx_start     request to accept din (taken when tx_ready is high)
//   din          data word, copied into the holding register on acceptance
//   tx_ready     holding register empty
//   tx           registered serial output, idle high
//   tx_busy      FSM outside IDLE
//   tx_done_tick one-clk pulse at the end of the stop period
module uart_tx #(
  parameter int DBIT    = 8,   // data bits per frame
  parameter int DB_TICK = 16,  // ticks per start/data/parity bit
  parameter int SB_TICK = 16,  // ticks per stop period
  parameter int PARITY  = 0    // 0 none, 1 even, 2 odd
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx_ready,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  // The tick counter must reach the larger of the two period lengths.
  localparam int TMAX = (DB_TICK > SB_TICK) ? DB_TICK : SB_TICK;
  localparam int SW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int NW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_DB_LAST = SW'(DB_TICK - 1);
  localparam logic [SW-1:0] S_SB_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);
  localparam logic          PAR_INV   = (PARITY == 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;

  logic [DBIT-1:0] hold_q;
  logic            hold_full_q;
  logic            accept;
  logic            load;

  // Acceptance and hand-off to the FSM are mutually exclusive: accept needs
  // an empty register, load needs a full one.
  assign accept = tx_start && !hold_full_q;
  assign load   = (state_q == IDLE) && hold_full_q;

  // ------------------------------------------------------------------
  // Holding register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      if (accept) begin
        hold_q      <= din;
        hold_full_q <= 1'b1;
      end else if (load) begin
        hold_full_q <= 1'b0;
      end
    end
  end

  // ------------------------------------------------------------------
  // FSM state and datapath registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    par_d   = par_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // Leave IDLE without waiting for a tick so back-to-back frames
        // carry no idle gap.
        if (load) begin
          b_d     = hold_q;
          par_d   = (^hold_q) ^ PAR_INV;
          s_d     = '0;
          state_d = START;
        end
      end

      START: begin
        if (tick) begin
          if (s_q == S_DB_LAST) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (s_q == S_DB_LAST) begin
            b_d = b_q >> 1;
            s_d = '0;
            if (n_q == N_LAST) begin
              state_d = (PARITY != 0) ? PAR : STOP;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      PAR: begin
        if (tick) begin
          if (s_q == S_DB_LAST) begin
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (s_q == S_SB_LAST) begin
            s_d     = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        s_d     = '0;
        n_d     = '0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Line value for the next state, registered so tx never glitches and
  // only moves on a tick edge or on IDLE exit.
  // ------------------------------------------------------------------
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_d[0];
      PAR:     tx_d = par_d;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  assign tx           = tx_q;
  assign tx_ready     = !hold_full_q;
  assign tx_busy      = (state_q != IDLE);
  assign tx_done_tick = done_q;

endmodule
